mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter TIMEOUT, 64, max cycles waiting for i_mem_ack before abort (>=2).
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_inst_req  in  1  instruction fetch request; held with i_inst_addr until o_inst_ack.
REQ-006 i_inst_addr  in  XLEN  fetch address.
REQ-007 o_inst_ack  out  1  one-cycle completion pulse, fetch side.
REQ-008 o_inst_data  out  XLEN  fetched word; valid while o_inst_ack=1.
REQ-009 i_data_req  in  1  load/store request; held with operands until o_data_ack.
REQ-010 i_data_addr  in  XLEN  load/store address.
REQ-011 i_data_wdata  in  XLEN  store data.
REQ-012 i_funct3  in  3  access size/sign code.
REQ-013 i_readwrite  in  1  0=read, 1=write.
REQ-014 o_data_ack  out  1  one-cycle completion pulse, data side.
REQ-015 o_data_rdata  out  XLEN  load result; valid while o_data_ack=1.
REQ-016 o_err  out  1  timeout flag; valid only with an ack pulse.
REQ-017 o_mem_req, o_mem_addr, o_mem_wdata, o_mem_funct3, o_mem_rw  out  1/XLEN/XLEN/3/1  unified memory port, all registered.
REQ-018 i_mem_ack  in  1  memory completion; i_mem_rdata  in  XLEN  read data, valid with i_mem_ack.

Function
REQ-019 FSM states: IDLE, WAIT_I, WAIT_D, RESP; one transaction in flight at most.
REQ-020 IDLE, only i_inst_req -> WAIT_I; only i_data_req -> WAIT_D; neither -> stay IDLE.
REQ-021 IDLE, both requests -> grant side opposite to last_grant bit; last_grant reset value = inst (first contention grants data).
REQ-022 On grant, last_grant updated and requester fields latched into o_mem_* registers; o_mem_req=1 from next cycle.
REQ-023 Fetch grant drives o_mem_rw=0, o_mem_funct3=3'b010, o_mem_wdata=0; data grant copies i_readwrite, i_funct3, i_data_wdata.
REQ-024 o_mem_* held constant throughout WAIT_I/WAIT_D regardless of requester input changes.
REQ-025 WAIT_x with i_mem_ack=1 -> RESP; i_mem_rdata captured; o_mem_req=0 in RESP.
REQ-026 RESP lasts exactly one cycle: matching o_x_ack=1, o_x_data/o_data_rdata = captured word, o_err=0; then IDLE.
REQ-027 Data-side write: o_data_rdata=0 during ack.
REQ-028 Wait counter cleared on grant, increments each WAIT cycle; reaching TIMEOUT-1 without i_mem_ack -> RESP with o_err=1, data=0, o_mem_req dropped.
REQ-029 i_mem_ack coincident with timeout expiry: ack wins, o_err=0.
REQ-030 i_mem_ack in IDLE or RESP ignored; no ack pulse, no state change.
REQ-031 Latency: request sampled in IDLE at cycle 0 -> o_mem_req at cycle 1 -> i_mem_ack at cycle k>=1 -> o_x_ack at k+1; minimum 2 cycles.
REQ-032 Any request high in IDLE, including one still asserted the cycle after its ack, is a new request.
REQ-033 o_inst_ack and o_data_ack never asserted in the same cycle.

Reset
REQ-034 i_rst=1 -> next edge: state IDLE, all outputs 0, last_grant=inst, counter 0.
REQ-035 Reset mid-transaction aborts it: no ack pulse issued, o_mem_req=0 next cycle.

Verification
REQ-036 Fetch only, addr 0x0000_0010, memory acks 1 cycle after req with 0x0051_0093 -> o_inst_ack one pulse at cycle 3, o_inst_data=0x0051_0093, o_mem_rw=0.
REQ-037 Both req same cycle after reset -> data granted first; next IDLE with both pending -> fetch granted; strict alternation over 8 transactions.
REQ-038 Store addr 0x100, wdata 0xDEAD_BEEF, funct3=3'b010 -> o_mem_rw=1, o_mem_wdata=0xDEAD_BEEF; o_data_ack pulse, o_data_rdata=0.
REQ-039 TIMEOUT=8, memory never acks -> o_mem_req high 8 cycles then low, o_data_ack=1 with o_err=1, data 0; later request serviced normally.
REQ-040 i_rst=1 while WAIT_D -> no ack pulse, o_mem_req=0 next cycle; stray i_mem_ack in IDLE -> no response.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and load/store share one
// registered memory port, with round-robin on contention and a wait timeout.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  output logic            o_inst_ack,
  output logic [XLEN-1:0] o_inst_data,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wdata,
  input  logic [2:0]      i_funct3,
  input  logic            i_readwrite,
  output logic            o_data_ack,
  output logic [XLEN-1:0] o_data_rdata,
  output logic            o_err,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [2:0]      o_mem_funct3,
  output logic            o_mem_rw,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_grant / resp_side: 0 = fetch, 1 = data
  logic            last_grant;
  logic            resp_side;
  logic            resp_err;
  logic [XLEN-1:0] resp_data;
  logic [CW-1:0]   cnt;
  logic            gnt_i;
  logic            gnt_d;
  logic            done_ack;
  logic            done_to;
  logic            waiting;

  assign waiting = (state == WAIT_I) || (state == WAIT_D);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_inst_req && i_data_req) begin
          gnt_i = last_grant;
          gnt_d = !last_grant;
        end else begin
          gnt_i = i_inst_req;
          gnt_d = i_data_req;
        end
        if (gnt_i)      state_nxt = WAIT_I;
        else if (gnt_d) state_nxt = WAIT_D;
      end
      WAIT_I, WAIT_D: begin
        // a memory ack on the final wait cycle beats the timeout
        if (i_mem_ack) begin
          done_ack  = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_MAX) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant   <= 1'b0;
      resp_side    <= 1'b0;
      resp_err     <= 1'b0;
      resp_data    <= '0;
      cnt          <= '0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_funct3 <= 3'b000;
      o_mem_rw     <= 1'b0;
    end else begin
      if (gnt_i) begin
        last_grant   <= 1'b0;
        resp_side    <= 1'b0;
        cnt          <= '0;
        o_mem_req    <= 1'b1;
        o_mem_addr   <= i_inst_addr;
        o_mem_wdata  <= '0;
        o_mem_funct3 <= 3'b010;
        o_mem_rw     <= 1'b0;
      end else if (gnt_d) begin
        last_grant   <= 1'b1;
        resp_side    <= 1'b1;
        cnt          <= '0;
        o_mem_req    <= 1'b1;
        o_mem_addr   <= i_data_addr;
        o_mem_wdata  <= i_data_wdata;
        o_mem_funct3 <= i_funct3;
        o_mem_rw     <= i_readwrite;
      end else if (waiting) begin
        cnt <= cnt + CW'(1);
      end
      if (done_ack) begin
        o_mem_req <= 1'b0;
        resp_err  <= 1'b0;
        resp_data <= (resp_side && o_mem_rw) ? '0 : i_mem_rdata;
      end else if (done_to) begin
        o_mem_req <= 1'b0;
        resp_err  <= 1'b1;
        resp_data <= '0;
      end
    end
  end

  assign o_inst_ack   = (state == RESP) && !resp_side;
  assign o_data_ack   = (state == RESP) && resp_side;
  assign o_err        = (state == RESP) && resp_err;
  assign o_inst_data  = o_inst_ack ? resp_data : '0;
  assign o_data_rdata = o_data_ack ? resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, round-robin, timeout,
// ack-vs-timeout race, reset abort and stray acks.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            i_clk;
  logic            i_rst;
  logic            i_inst_req;
  logic [XLEN-1:0] i_inst_addr;
  logic            o_inst_ack;
  logic [XLEN-1:0] o_inst_data;
  logic            i_data_req;
  logic [XLEN-1:0] i_data_addr;
  logic [XLEN-1:0] i_data_wdata;
  logic [2:0]      i_funct3;
  logic            i_readwrite;
  logic            o_data_ack;
  logic [XLEN-1:0] o_data_rdata;
  logic            o_err;
  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [2:0]      o_mem_funct3;
  logic            o_mem_rw;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  int n_checks;
  int n_fail;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_inst_req   (i_inst_req),
    .i_inst_addr  (i_inst_addr),
    .o_inst_ack   (o_inst_ack),
    .o_inst_data  (o_inst_data),
    .i_data_req   (i_data_req),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .i_funct3     (i_funct3),
    .i_readwrite  (i_readwrite),
    .o_data_ack   (o_data_ack),
    .o_data_rdata (o_data_rdata),
    .o_err        (o_err),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_funct3 (o_mem_funct3),
    .o_mem_rw     (o_mem_rw),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_inst_req   = 1'b0;
    i_inst_addr  = '0;
    i_data_req   = 1'b0;
    i_data_addr  = '0;
    i_data_wdata = '0;
    i_funct3     = 3'b000;
    i_readwrite  = 1'b0;
    i_mem_ack    = 1'b0;
    i_mem_rdata  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1'b1;
    tick();
    n_checks++;
    if ({o_inst_ack, o_data_ack, o_err, o_mem_req, o_mem_rw} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00000",
               {o_inst_ack, o_data_ack, o_err, o_mem_req, o_mem_rw});
    end
    n_checks++;
    if ({o_mem_addr, o_mem_wdata, o_inst_data, o_data_rdata} !== '0
        || o_mem_funct3 !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_buses got %h/%h/%h exp 0",
               o_mem_addr, o_mem_wdata, o_mem_funct3);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    i_inst_req  = 1'b1;
    i_inst_addr = 32'h0000_0010;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h10 || o_mem_rw !== 1'b0
        || o_mem_funct3 !== 3'b010 || o_mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL fetch_port got req=%b a=%h rw=%b f3=%b wd=%h exp 1/10/0/010/0",
               o_mem_req, o_mem_addr, o_mem_rw, o_mem_funct3, o_mem_wdata);
    end
    n_checks++;
    if (o_inst_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_early_ack c1 got %b exp 0", o_inst_ack);
    end
    tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h0051_0093;
    n_checks++;
    if (o_inst_ack !== 1'b0 || o_mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_c2 got ack=%b req=%b exp 0/1", o_inst_ack, o_mem_req);
    end
    tick();
    n_checks++;
    if (o_inst_ack !== 1'b1 || o_inst_data !== 32'h0051_0093
        || o_err !== 1'b0 || o_data_ack !== 1'b0 || o_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp got ack=%b d=%h err=%b dack=%b req=%b exp 1/00510093/0/0/0",
               o_inst_ack, o_inst_data, o_err, o_data_ack, o_mem_req);
    end
    i_inst_req = 1'b0;
    i_mem_ack  = 1'b0;
    tick();
    n_checks++;
    if (o_inst_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse_width got %b exp 0", o_inst_ack);
    end
  endtask

  task automatic test_store();
    i_data_req   = 1'b1;
    i_data_addr  = 32'h100;
    i_data_wdata = 32'hDEAD_BEEF;
    i_funct3     = 3'b010;
    i_readwrite  = 1'b1;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b1 || o_mem_rw !== 1'b1 || o_mem_addr !== 32'h100
        || o_mem_wdata !== 32'hDEAD_BEEF || o_mem_funct3 !== 3'b010) begin
      n_fail++;
      $display("FAIL store_port got req=%b rw=%b a=%h wd=%h f3=%b exp 1/1/100/deadbeef/010",
               o_mem_req, o_mem_rw, o_mem_addr, o_mem_wdata, o_mem_funct3);
    end
    i_data_addr  = 32'h0;
    i_data_wdata = 32'h0;
    i_readwrite  = 1'b0;
    i_funct3     = 3'b001;
    tick();
    n_checks++;
    if (o_mem_addr !== 32'h100 || o_mem_wdata !== 32'hDEAD_BEEF
        || o_mem_rw !== 1'b1 || o_mem_funct3 !== 3'b010) begin
      n_fail++;
      $display("FAIL store_hold got a=%h wd=%h rw=%b f3=%b exp 100/deadbeef/1/010",
               o_mem_addr, o_mem_wdata, o_mem_rw, o_mem_funct3);
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    tick();
    n_checks++;
    if (o_data_ack !== 1'b1 || o_data_rdata !== '0 || o_inst_ack !== 1'b0
        || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp got dack=%b rd=%h iack=%b err=%b exp 1/0/0/0",
               o_data_ack, o_data_rdata, o_inst_ack, o_err);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic            exp_data;
    logic [XLEN-1:0] rd;
    do_reset();
    i_inst_req  = 1'b1;
    i_inst_addr = 32'h200;
    i_data_req  = 1'b1;
    i_data_addr = 32'h300;
    i_funct3    = 3'b100;
    i_readwrite = 1'b0;
    for (int t = 0; t < 8; t++) begin
      exp_data = (t % 2) == 0;
      rd = exp_data ? 32'h1000 + t : 32'h2000 + t;
      tick();
      n_checks++;
      if (o_mem_req !== 1'b1
          || o_mem_addr !== (exp_data ? 32'h300 : 32'h200)
          || o_mem_funct3 !== (exp_data ? 3'b100 : 3'b010)) begin
        n_fail++;
        $display("FAIL rr_grant t=%0d got req=%b a=%h f3=%b exp data=%b",
                 t, o_mem_req, o_mem_addr, o_mem_funct3, exp_data);
      end
      i_mem_ack   = 1'b1;
      i_mem_rdata = rd;
      tick();
      n_checks++;
      if (o_data_ack !== exp_data || o_inst_ack !== !exp_data
          || (exp_data ? o_data_rdata : o_inst_data) !== rd) begin
        n_fail++;
        $display("FAIL rr_resp t=%0d got dack=%b iack=%b id=%h rd=%h exp word %h",
                 t, o_data_ack, o_inst_ack, o_inst_data, o_data_rdata, rd);
      end
      i_mem_ack = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    i_data_req  = 1'b1;
    i_data_addr = 32'h40;
    i_readwrite = 1'b0;
    i_funct3    = 3'b010;
    tick();
    hi = 0;
    while (o_mem_req === 1'b1 && hi < 20) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi !== TO) begin
      n_fail++;
      $display("FAIL timeout_req_len got %0d exp %0d", hi, TO);
    end
    n_checks++;
    if (o_data_ack !== 1'b1 || o_err !== 1'b1 || o_data_rdata !== '0) begin
      n_fail++;
      $display("FAIL timeout_resp got dack=%b err=%b rd=%h exp 1/1/0",
               o_data_ack, o_err, o_data_rdata);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (o_data_ack !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after got dack=%b err=%b exp 0/0", o_data_ack, o_err);
    end
    i_inst_req  = 1'b1;
    i_inst_addr = 32'h80;
    tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hCAFE_0001;
    tick();
    n_checks++;
    if (o_inst_ack !== 1'b1 || o_err !== 1'b0 || o_inst_data !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL post_timeout got iack=%b err=%b d=%h exp 1/0/cafe0001",
               o_inst_ack, o_err, o_inst_data);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_at_expiry();
    i_data_req  = 1'b1;
    i_data_addr = 32'h44;
    i_readwrite = 1'b0;
    tick();
    for (int c = 1; c < TO; c++) tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h0BAD_F00D;
    n_checks++;
    if (o_mem_req !== 1'b1 || o_data_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL race_last_wait got req=%b dack=%b exp 1/0", o_mem_req, o_data_ack);
    end
    tick();
    n_checks++;
    if (o_data_ack !== 1'b1 || o_err !== 1'b0 || o_data_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL race_resp got dack=%b err=%b rd=%h exp 1/0/0badf00d",
               o_data_ack, o_err, o_data_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_abort();
    i_data_req  = 1'b1;
    i_data_addr = 32'h48;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre got req=%b exp 1", o_mem_req);
    end
    i_rst      = 1'b1;
    i_mem_ack  = 1'b1;
    i_data_req = 1'b0;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0 || o_data_ack !== 1'b0 || o_inst_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rst got req=%b dack=%b iack=%b exp 0/0/0",
               o_mem_req, o_data_ack, o_inst_ack);
    end
    i_rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0 || o_data_ack !== 1'b0 || o_inst_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack got req=%b dack=%b iack=%b exp 0/0/0",
               o_mem_req, o_data_ack, o_inst_ack);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_timeout();
    test_ack_at_expiry();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
